// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: controller state
// encoding and the byte-lane count helper.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, architectural zero register and
// byte-lane merge of same-cycle write data when forwarding is enabled.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                raddr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    mem_flat,
  input  logic                             byp_en,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [lane_count(DATA_W)-1:0]    wbe,
  output logic [DATA_W-1:0]                rdata
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] arr_word;
  logic              zero_hit;
  logic              byp_hit;

  assign arr_word = mem_flat[int'(raddr)*DATA_W +: DATA_W];
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  assign byp_hit  = (BYPASS != 0) && byp_en && (waddr == raddr);

  // Zero register wins over forwarding so r0 can never leak write data.
  always_comb begin
    rdata = arr_word;
    if (zero_hit) begin
      rdata = '0;
    end else if (byp_hit) begin
      for (int k = 0; k < LANES; k++) begin
        if (wbe[k]) rdata[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised decode-stage register file with byte-enable writes, optional
// write-to-read forwarding and a one-entry-per-cycle bulk-clear sweep.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*ADDR_W-1:0]      raddr,
  output logic [NUM_RD*DATA_W-1:0]      rdata,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [lane_count(DATA_W)-1:0] wbe,
  input  logic                          clr_req,
  output logic                          busy,
  output logic                          clr_done,
  output logic                          wr_drop
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = lane_count(DATA_W);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_idx;
  logic [ADDR_W-1:0]   clr_idx_nxt;
  logic                clr_last;
  logic                wr_ok;
  logic                byp_en;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  assign clr_last = (state == ST_CLEAR) && (clr_idx == ADDR_W'(DEPTH - 1));
  assign wr_ok    = (state == ST_IDLE) && we &&
                    !((ZERO_REG != 0) && (waddr == '0));
  assign byp_en   = (state == ST_IDLE) && we;

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end
      end
      ST_CLEAR: begin
        // The natural wrap of clr_idx back to 0 coincides with the sweep end.
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_last) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        clr_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      clr_idx  <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_idx  <= clr_idx_nxt;
      busy     <= (state_nxt == ST_CLEAR);
      clr_done <= clr_last;
      wr_drop  <= we && (state == ST_CLEAR);
    end
  end

  // Storage: the sweep owns the array while clearing, writeback otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .raddr    (raddr[p*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .byp_en   (byp_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .wbe      (wbe),
      .rdata    (rdata[p*DATA_W +: DATA_W])
    );
  end

endmodule
